riscv_aes_result_buffer: RTL
============================

Name: riscv_aes_result_buffer

Overview:
- Receive side of the AES datapath.
- Captures one 128-bit block from the AES engine in a single parallel transfer, using a valid/ready handshake.
- Returns the block to the RISC-V core one 32-bit word at a time through an addressed read port.
- Applies backpressure to the AES engine until the core has read every word of the current block, or until software clears the buffer.

Parameters:
DATA_WIDTH, 32, width of one word
NUM_WORDS, 4, words per block
ADDR_WIDTH, 2, read address width; must equal clog2(NUM_WORDS)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
test_en_i  input  1  test mode: freezes the FSM and the unread mask
blk_valid_i  input  1  AES engine presents a block
blk_data_i  input  NUM_WORDS*DATA_WIDTH  block; word i = blk_data_i[i*DATA_WIDTH +: DATA_WIDTH]
blk_ready_o  output  1  buffer can accept a block
ren_i  input  1  core read request
raddr_i  input  ADDR_WIDTH  word index to read
rdata_o  output  DATA_WIDTH  read data, registered
rvalid_o  output  1  one-cycle pulse; rdata_o is valid
rd_err_o  output  1  one-cycle pulse alongside rvalid_o: the read was issued while EMPTY
clear_i  input  1  synchronous flush
full_o  output  1  a block is held
words_left_o  output  ADDR_WIDTH+1  number of words not yet read

Behaviour:
- Reset (async, rst=1):
  - state EMPTY; holding register = 0; unread mask = 0.
  - rdata_o = 0; rvalid_o = 0; rd_err_o = 0.
  - blk_ready_o = 1; full_o = 0; words_left_o = 0.
  - Reset may be asserted mid-block or mid-read; all in-flight data and pending pulses are discarded.
- State machine: two states, EMPTY and FULL.
  - blk_ready_o = (state==EMPTY) && !test_en_i. It is a pure function of registered state, so there is no combinational path from blk_valid_i.
  - full_o = (state==FULL).
  - words_left_o = popcount(mask).
- EMPTY -> FULL:
  - Condition: blk_valid_i && blk_ready_o at a clock edge.
  - Capture blk_data_i into the holding register; mask = all ones.
  - full_o and words_left_o=4 are visible the next cycle.
  - The AES engine must hold blk_valid_i and blk_data_i stable until the transfer. There is no drop and no overflow path.
- Read port (one-cycle latency):
  - A request with ren_i=1 at edge N produces rvalid_o=1 at cycle N+1.
  - In FULL, rdata_o = holding word[raddr_i] and mask[raddr_i] is cleared.
  - Re-reading a word that has already been read returns the same data. The mask is unchanged and this is not an error.
  - Back-to-back reads are allowed, one per cycle.
- FULL -> EMPTY:
  - Transition occurs at the edge where a read clears the last set mask bit.
  - blk_ready_o=1 in the following cycle.
  - A new block can therefore be captured at the earliest one cycle after the final read.
- Read while EMPTY: rdata_o = 0, rvalid_o = 1, rd_err_o = 1. No state change.
- clear_i:
  - Effect: state = EMPTY, mask = 0, holding register = 0.
  - It has priority over a capture and over mask updates in the same cycle.
  - A read in the same cycle as clear_i still completes, using pre-clear contents. rvalid_o pulses next cycle and rd_err_o is computed from the pre-clear state.
- Simultaneous capture and read:
  - A capture can only occur in EMPTY, so a read in the same cycle sees EMPTY.
  - Result: rd_err_o=1, and the capture proceeds normally.
- test_en_i=1:
  - blk_ready_o=0; state and mask frozen; clear_i still honoured.
  - Reads return holding-register contents but do not modify the mask.
- rvalid_o and rd_err_o are low in every cycle not following a read request.
- Out-of-range raddr_i is impossible because ADDR_WIDTH = clog2(NUM_WORDS).

Test Plan:
- Reset, then capture 0x0F0E0D0C_0B0A0908_07060504_03020100.
  - Required: full_o=1, words_left_o=4, blk_ready_o=0 next cycle.
- Read addresses 3,2,1,0 back-to-back.
  - Required: rdata_o=0x0F0E0D0C, 0x0B0A0908, 0x07060504, 0x03020100 on consecutive cycles, one cycle after each request.
  - Required: words_left_o goes 3,2,1,0; blk_ready_o=1 the cycle after the final read.
- Read addr 1 twice, then 0, 2, 3.
  - Required: both addr-1 reads return the same word; words_left_o stays 3 after the second; EMPTY only after addr 3.
- Hold blk_valid_i high with a second block while FULL.
  - Required: no capture; the first block stays intact.
  - Required: after the last read, the second block is captured exactly one cycle after blk_ready_o rises.
- Read in EMPTY.
  - Required: rdata_o=0, rvalid_o=1, rd_err_o=1.
- Assert clear_i with a read of addr 2 and blk_valid_i in the same cycle while FULL.
  - Required: the read returns the pre-clear word 2; state EMPTY, words_left_o=0, no capture.
- Assert rst asynchronously mid-read.
  - Required: outputs at reset values immediately, with no rvalid_o pulse.

Source files
------------

// File: rtl/riscv_aes_result_buffer.sv
// riscv_aes_result_buffer
// Receive side of the AES datapath. Captures a whole block from the AES engine
// in one valid/ready transfer and hands it to the core one word at a time
// through an addressed, registered read port. The engine is held off until
// every word has been read once, or until software clears the buffer.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   test_en_i      freezes FSM and unread mask, blocks new captures
//   blk_valid_i    AES engine presents blk_data_i
//   blk_data_i     block; word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   blk_ready_o    buffer can accept a block (registered-state only)
//   ren_i/raddr_i  core read request and word index
//   rdata_o        registered read data
//   rvalid_o       one-cycle pulse, rdata_o valid
//   rd_err_o       one-cycle pulse with rvalid_o: read issued while empty
//   clear_i        synchronous flush
//   full_o         a block is held
//   words_left_o   number of words not yet read
module riscv_aes_result_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            test_en_i,
  input  logic                            blk_valid_i,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] blk_data_i,
  output logic                            blk_ready_o,
  input  logic                            ren_i,
  input  logic [ADDR_WIDTH-1:0]           raddr_i,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            rvalid_o,
  output logic                            rd_err_o,
  input  logic                            clear_i,
  output logic                            full_o,
  output logic [ADDR_WIDTH:0]             words_left_o
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                                state_q, state_d;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  data_q, data_d;
  logic [NUM_WORDS-1:0]                  mask_q, mask_d;
  logic [NUM_WORDS-1:0]                  mask_rd;
  logic [DATA_WIDTH-1:0]                 rdata_q, rdata_d;
  logic                                  rvalid_q, rvalid_d;
  logic                                  rd_err_q, rd_err_d;
  logic                                  capture;
  logic [CntW-1:0]                       cnt;

  assign blk_ready_o  = (state_q == StEmpty) && !test_en_i;
  assign full_o       = (state_q == StFull);
  assign capture      = blk_valid_i && blk_ready_o;
  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign rd_err_o     = rd_err_q;
  assign words_left_o = cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      cnt = cnt + CntW'(mask_q[i]);
    end
  end

  // State, mask and holding register. Clear beats capture and mask updates;
  // test mode freezes everything except clear.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    mask_rd = mask_q;
    mask_rd[raddr_i] = 1'b0;
    if (clear_i) begin
      state_d = StEmpty;
      mask_d  = '0;
      data_d  = '0;
    end else if (!test_en_i) begin
      if (capture) begin
        state_d = StFull;
        mask_d  = '1;
        data_d  = blk_data_i;
      end else if (ren_i && (state_q == StFull)) begin
        mask_d = mask_rd;
        if (mask_rd == '0) begin
          state_d = StEmpty;
        end
      end
    end
  end

  // Read port always uses pre-update contents, so a read alongside clear or
  // capture sees the state as it was at the edge.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rd_err_d = 1'b0;
    if (ren_i) begin
      rvalid_d = 1'b1;
      if (state_q == StFull) begin
        rdata_d = data_q[raddr_i];
      end else begin
        rdata_d  = '0;
        rd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StEmpty;
      mask_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rd_err_q <= rd_err_d;
    end
  end

endmodule
